modu_sel_xfade: RTL and testbench
=================================

Name: modu_sel_xfade

Overview:
- Parametrised successor to the modulation-output selector: routes one of N_CH modulator sample streams to the DAC path.
- Mode changes never hard-switch. The output ramps to mid-scale, changes channel, then ramps back up. This removes DAC step glitches when the MCU changes modulation mode.
- Sits between the modulator bank and the DAC interface. Controlled by the MCU control byte plus a strobe.

Parameters:
- N_CH, 8: number of input channels (2..256).
- DW, 12: sample width; unsigned offset-binary, mid-scale 2^(DW-1).
- GW, 8: gain fraction bits; unity gain = 2^GW.
- STEP, 16: gain change per tick; must divide 2^GW.
- TICK_DIV, 1: clk cycles per gain tick (>=1).
- DEF_SEL, 0: channel selected after reset.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- cov_data, input, 8: MCU control byte; channel request = cov_data[SELW-1:0], where SELW = max(1, clog2(N_CH)).
- cov_valid, input, 1: one-cycle strobe qualifying cov_data.
- ch_data, input, N_CH*DW: flattened channel samples; channel k occupies bits [k*DW +: DW].
- modu_out, output, DW: faded, selected sample.
- active_sel, output, 8: channel currently routed, zero-extended.
- busy, output, 1: high while a switch is in progress.
- sel_err, output, 1: one-cycle pulse on an out-of-range request.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - modu_out = 2^(DW-1); active_sel = DEF_SEL; target = DEF_SEL.
  - gain g = 2^GW; state = RUN; busy = 0; sel_err = 0; tick counter = 0.
- Datapath, 2-cycle latency from ch_data to modu_out:
  - Stage 1 registers d = ch_data[active_sel] - 2^(DW-1) as signed (DW+1 bits), together with g.
  - Stage 2 registers modu_out = 2^(DW-1) + ((d*g) >>> GW). The shift is arithmetic (floor). The result is saturated to [0, 2^DW-1].
- Tick: a counter generates one gain tick every TICK_DIV cycles while the state is FADE_OUT or FADE_IN. The counter clears on every state entry.
- Request decode, applied on cycles where cov_valid = 1:
  - req >= N_CH: sel_err pulses on the next cycle; the request is otherwise ignored in every state.
  - RUN, req == active_sel: ignored.
  - RUN, req != active_sel: target <= req; state goes to FADE_OUT on the next cycle; busy = 1.
  - FADE_OUT or SWAP: target <= req (the latest request wins).
  - FADE_IN, req != active_sel: target <= req; state returns to FADE_OUT; the fade-out starts from the current g.
  - FADE_IN, req == active_sel: ignored.
- States:
  - RUN: g = 2^GW; busy = 0.
  - FADE_OUT: each tick, g <= g - STEP. When g reaches 0, go to SWAP.
  - SWAP: exactly one cycle. active_sel <= target; g stays 0.
    - If target == the old active_sel (the request was reverted mid-fade), the swap is still taken, then FADE_IN.
  - FADE_IN: each tick, g <= g + STEP. When g reaches 2^GW, go to RUN; busy falls in the same cycle.
- Switch time (no interruptions): (2^GW/STEP)*TICK_DIV cycles fade-out + 1 cycle SWAP + (2^GW/STEP)*TICK_DIV cycles fade-in. Defaults give 16 + 1 + 16 = 33 cycles.
- The sample at modu_out reflects active_sel and g two cycles after they change.
- Out-of-range requests never change target, state, g or active_sel.
- Reset asserted mid-switch restores all reset values immediately. No pending request survives reset.

Test Plan:
- Reset then release, ch0 held at 3000, defaults: modu_out = 2048 during reset; 3000 from the 2nd cycle after release; busy = 0; active_sel = 0.
- ch0 = 3000, ch3 = 1000, request 3 in RUN:
  - busy rises next cycle.
  - modu_out passes 2524 at g = 128, then reaches 2048 at g = 0.
  - active_sel = 3 after 17 cycles.
  - Fade-in passes 1524 at g = 128 and settles at 1000.
  - busy falls 33 cycles after the strobe.
- Request 9 with N_CH = 8: sel_err pulses for one cycle; active_sel, modu_out and busy are unchanged.
- Request 3, then request 5 during FADE_OUT: only one SWAP occurs and active_sel = 5.
  - A request for 2 issued during the following FADE_IN restarts FADE_OUT from the current g, with no output step larger than one STEP increment.
- Request equal to active_sel in RUN: no busy, output unchanged.
  - TICK_DIV = 4 switch: total switch time = 16*4 + 1 + 16*4 = 129 cycles.
- Assert rst at g = 64 during FADE_OUT: modu_out = 2048 immediately, active_sel = DEF_SEL, busy = 0. Normal operation resumes after release.

Source files
------------

// File: rtl/modu_sel_xfade.sv
// N_CH-way modulator output selector with gain crossfade through mid-scale.
// A channel change ramps gain to zero, swaps the channel, then ramps gain back to unity.
module modu_sel_xfade #(
    parameter int N_CH     = 8,
    parameter int DW       = 12,
    parameter int GW       = 8,
    parameter int STEP     = 16,
    parameter int TICK_DIV = 1,
    parameter int DEF_SEL  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         cov_data,
    input  logic               cov_valid,
    input  logic [N_CH*DW-1:0] ch_data,
    output logic [DW-1:0]      modu_out,
    output logic [7:0]         active_sel,
    output logic               busy,
    output logic               sel_err
);

    localparam int SELW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW   = DW + GW + 3;

    localparam logic [GW:0]          G_UNITY = {1'b1, {GW{1'b0}}};
    localparam logic [GW:0]          G_STEP  = (GW+1)'(STEP);
    localparam logic [TW-1:0]        TICK_TC = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0]        MID     = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [PW-1:0] MID_W   = PW'(2**(DW-1));
    localparam logic signed [PW-1:0] MAX_W   = PW'((2**DW) - 1);

    typedef enum logic [1:0] {RUN, FADE_OUT, SWAP, FADE_IN} state_t;

    state_t          state_q;
    logic [GW:0]     g_q;
    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] target_q;
    logic [TW-1:0]   tick_q;
    logic            busy_q;
    logic            sel_err_q;

    logic [SELW-1:0] req;
    logic            in_range;
    logic            req_ok;
    logic            tick;

    assign req      = cov_data[SELW-1:0];
    assign in_range = ({24'd0, cov_data} < 32'(N_CH));
    assign req_ok   = cov_valid && in_range;
    assign tick     = (tick_q == TICK_TC);

    // Requests in FADE_IN reverse direction from the current gain, never from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            g_q       <= G_UNITY;
            sel_q     <= SELW'(DEF_SEL);
            target_q  <= SELW'(DEF_SEL);
            tick_q    <= '0;
            busy_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= cov_valid && !in_range;
            case (state_q)
                RUN: begin
                    if (req_ok && (req != sel_q)) begin
                        target_q <= req;
                        state_q  <= FADE_OUT;
                        busy_q   <= 1'b1;
                        tick_q   <= '0;
                    end
                end
                FADE_OUT: begin
                    if (req_ok) target_q <= req;
                    if (tick) begin
                        tick_q <= '0;
                        g_q    <= g_q - G_STEP;
                        if (g_q == G_STEP) state_q <= SWAP;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                SWAP: begin
                    sel_q    <= req_ok ? req : target_q;
                    target_q <= req_ok ? req : target_q;
                    state_q  <= FADE_IN;
                    tick_q   <= '0;
                end
                FADE_IN: begin
                    if (req_ok && (req != sel_q)) begin
                        target_q <= req;
                        state_q  <= FADE_OUT;
                        tick_q   <= '0;
                    end else if (tick) begin
                        tick_q <= '0;
                        g_q    <= g_q + G_STEP;
                        if (g_q == (G_UNITY - G_STEP)) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    logic [DW-1:0]        samp_d;
    logic signed [DW:0]   d_d;
    logic signed [DW:0]   d1_q;
    logic [GW:0]          g1_q;
    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] sum_d;
    logic [DW-1:0]        out_d;
    logic [DW-1:0]        out_q;

    assign samp_d = ch_data[sel_q*DW +: DW];
    assign d_d    = signed'({1'b0, samp_d}) - signed'({2'b01, {(DW-1){1'b0}}});
    assign prod_d = d1_q * signed'({1'b0, g1_q});
    assign sum_d  = (prod_d >>> GW) + MID_W;

    always_comb begin
        out_d = sum_d[DW-1:0];
        if (sum_d < 0)          out_d = '0;
        else if (sum_d > MAX_W) out_d = '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q  <= '0;
            g1_q  <= G_UNITY;
            out_q <= MID;
        end else begin
            d1_q  <= d_d;
            g1_q  <= g_q;
            out_q <= out_d;
        end
    end

    assign modu_out   = out_q;
    assign active_sel = 8'(sel_q);
    assign busy       = busy_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_modu_sel_xfade.sv
// Bench for modu_sel_xfade: scoreboard of expected samples plus hand-timed switch sequences.
// A second instance runs with TICK_DIV = 4 to check the stretched switch time.
module tb_modu_sel_xfade;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, b_rst;
    logic [7:0]  cov_data, b_cov_data;
    logic        cov_valid, b_cov_valid;
    logic [95:0] ch_data;
    logic [11:0] modu_out, b_modu_out;
    logic [7:0]  active_sel, b_active_sel;
    logic        busy, b_busy, sel_err, b_sel_err;

    modu_sel_xfade u_a (
        .clk(clk), .rst(rst), .cov_data(cov_data), .cov_valid(cov_valid), .ch_data(ch_data),
        .modu_out(modu_out), .active_sel(active_sel), .busy(busy), .sel_err(sel_err)
    );

    modu_sel_xfade #(.TICK_DIV(4)) u_b (
        .clk(clk), .rst(b_rst), .cov_data(b_cov_data), .cov_valid(b_cov_valid), .ch_data(ch_data),
        .modu_out(b_modu_out), .active_sel(b_active_sel), .busy(b_busy), .sel_err(b_sel_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    int chval [8] = '{3000, 107, 2500, 1000, 407, 500, 607, 707};

    task automatic apply_ch();
        for (int k = 0; k < 8; k++) ch_data[k*12 +: 12] = 12'(chval[k]);
    endtask

    function automatic int fexp(input int x, input int g);
        int p;
        p = (x - 2048) * g;
        return 2048 + (p >>> 8);
    endfunction

    // Scoreboard: expected outputs keyed by the cycle they must appear on.
    typedef struct {
        int due;
        int out;
        int bsy;
        int sel;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check($sformatf("sb_out@%0d", e.due), int'(modu_out), e.out);
            if (e.bsy >= 0) check($sformatf("sb_busy@%0d", e.due), int'(busy), e.bsy);
            if (e.sel >= 0) check($sformatf("sb_sel@%0d", e.due), int'(active_sel), e.sel);
        end
    end

    function automatic int gm(input int j);
        if (j <= 0)  return 256;
        if (j <= 17) return 256 - 16*(j-1);
        if (j <= 34) return 16*(j-18);
        return 256;
    endfunction

    task automatic push_switch(input int c0, input int s_old, input int s_new);
        exp_t x;
        for (int k = 1; k <= 40; k++) begin
            x.due = c0 + k;
            x.out = fexp(chval[(k-2 >= 18) ? s_new : s_old], gm(k-2));
            x.bsy = (k <= 33) ? 1 : 0;
            x.sel = (k >= 18) ? s_new : s_old;
            sbq.push_back(x);
        end
    endtask

    task automatic strobe(input int v);
        cov_data  = 8'(v);
        cov_valid = 1'b1;
        @(negedge clk);
        cov_valid = 1'b0;
        cov_data  = 8'd0;
    endtask

    // Output-step and swap monitor for the interrupted-switch sequence.
    int mon_en = 0, maxstep = 0, prev_out = 0, prev_sel = 0, sel_changes = 0;
    always @(negedge clk) begin
        if (mon_en != 0) begin
            if (int'(modu_out) - prev_out > maxstep) maxstep = int'(modu_out) - prev_out;
            if (prev_out - int'(modu_out) > maxstep) maxstep = prev_out - int'(modu_out);
            if (int'(active_sel) != prev_sel) sel_changes++;
            prev_out = int'(modu_out);
            prev_sel = int'(active_sel);
        end
    end

    typedef struct {
        int s;
        int exp;
    } vec_t;

    initial begin
        vec_t tbl [8];
        exp_t x;
        int   k;
        tbl = '{'{0, 0}, '{4095, 4095}, '{2048, 2048}, '{2047, 2047},
                '{1, 1}, '{4094, 4094}, '{1234, 1234}, '{3000, 3000}};

        rst = 1'b1; b_rst = 1'b1;
        cov_data = 8'd0; cov_valid = 1'b0; b_cov_data = 8'd0; b_cov_valid = 1'b0;
        apply_ch();
        repeat (3) @(negedge clk);
        check("rst_out", int'(modu_out), 2048);
        check("rst_busy", int'(busy), 0);
        check("rst_sel", int'(active_sel), 0);
        check("rst_err", int'(sel_err), 0);
        check("rst_b_out", int'(b_modu_out), 2048);
        rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        check("rel_lat1", int'(modu_out), 2048);
        @(negedge clk);
        check("rel_lat2", int'(modu_out), 3000);

        // Unity-gain passthrough vectors on channel 0.
        for (int i = 0; i < 8; i++) begin
            chval[0] = tbl[i].s;
            apply_ch();
            x.due = cyc + 2; x.out = tbl[i].exp; x.bsy = 0; x.sel = 0;
            sbq.push_back(x);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);

        // Full switch 0 -> 3, every cycle predicted.
        push_switch(cyc, 0, 3);
        strobe(3);
        repeat (42) @(negedge clk);
        check("sw_final_out", int'(modu_out), 1000);

        // Out-of-range requests.
        strobe(9);
        check("err9_pulse", int'(sel_err), 1);
        check("err9_busy", int'(busy), 0);
        @(negedge clk);
        check("err9_clear", int'(sel_err), 0);
        strobe(8);
        check("err8_pulse", int'(sel_err), 1);
        strobe(255);
        check("err255_pulse", int'(sel_err), 1);
        repeat (3) @(negedge clk);
        check("err_sel", int'(active_sel), 3);
        check("err_busy", int'(busy), 0);
        check("err_out", int'(modu_out), 1000);

        // Request for the channel already active.
        strobe(3);
        for (int i = 0; i < 3; i++) begin
            check("same_busy", int'(busy), 0);
            @(negedge clk);
        end
        check("same_out", int'(modu_out), 1000);

        // Retarget during fade-out, then reverse during fade-in.
        prev_out = int'(modu_out); prev_sel = int'(active_sel); maxstep = 0; sel_changes = 0;
        mon_en = 1;
        strobe(0);
        repeat (3) @(negedge clk);
        strobe(5);
        k = 0;
        while (int'(active_sel) == 3 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("retarget_sel", int'(active_sel), 5);
        repeat (8) @(negedge clk);
        strobe(2);
        k = 1;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("reverse_time", k, 26);
        check("reverse_sel", int'(active_sel), 2);
        repeat (3) @(negedge clk);
        check("reverse_out", int'(modu_out), 2500);
        mon_en = 0;
        check("max_step_ok", int'(maxstep <= 100), 1);
        check("swap_count", sel_changes, 2);

        // TICK_DIV = 4 switch on the second instance.
        b_cov_data = 8'd3; b_cov_valid = 1'b1;
        @(negedge clk);
        b_cov_valid = 1'b0; b_cov_data = 8'd0;
        check("b_busy_rise", int'(b_busy), 1);
        k = 1;
        while (b_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("b_switch_time", k, 130);
        check("b_sel", int'(b_active_sel), 3);
        repeat (2) @(negedge clk);
        check("b_out", int'(b_modu_out), 1000);

        // Reset at g = 64 during fade-out.
        strobe(6);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out", int'(modu_out), 2048);
        check("midrst_sel", int'(active_sel), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_out", int'(modu_out), 3000);
        check("post_sel", int'(active_sel), 0);
        for (int i = 0; i < 4; i++) begin
            check("post_busy", int'(busy), 0);
            @(negedge clk);
        end

        k = 0;
        while (sbq.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("sb_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
